// File: rtl/square_melody_sequencer.sv
// Note-table sequencer that steps a square-wave tone generator
// through programmed half-periods and durations, with gaps and looping.
module square_melody_sequencer #(
    parameter int TICK_DIV  = 50000,
    parameter int GAP_TICKS = 10,
    parameter int ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W:0]   length,
    input  logic [15:0]       master_volume,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [20:0]       wr_half_period,
    input  logic [11:0]       wr_duration,
    output logic              enable,
    output logic [20:0]       half_period,
    output logic [15:0]       volume,
    output logic              busy,
    output logic [ADDR_W-1:0] note_idx,
    output logic              done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GLEN = GW'(GAP_TICKS);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    state_t            state_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] idx_q;
    logic [PW-1:0]     presc_q;
    logic [11:0]       dur_q;
    logic [GW-1:0]     gap_q;

    logic              enable_q;
    logic [20:0]       half_period_q;
    logic [15:0]       volume_q;
    logic              busy_q;
    logic [ADDR_W-1:0] note_idx_q;
    logic              done_q;

    // Table holds {half_period, duration}; deliberately not reset.
    logic [32:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= {wr_half_period, wr_duration};
        end
    end

    logic [20:0] rd_hp;
    logic [11:0] rd_dur;
    assign {rd_hp, rd_dur} = mem_q[idx_q];

    logic            tick;
    logic            len_ok;
    logic [ADDR_W:0] nxt_idx;
    logic            more;

    assign tick    = (presc_q == PMAX);
    assign len_ok  = (length != '0) && (length <= (ADDR_W+1)'(DEPTH));
    assign nxt_idx = {1'b0, idx_q} + 1'b1;
    assign more    = (nxt_idx < len_q);

    // End-of-note decision, shared by the PLAY and GAP exits.
    state_t            adv_state_d;
    logic [ADDR_W-1:0] adv_idx_d;
    logic              adv_done_d;

    always_comb begin
        adv_state_d = LOAD;
        adv_idx_d   = '0;
        adv_done_d  = 1'b0;
        if (more) begin
            adv_idx_d = idx_q + 1'b1;
        end else if (!loop_en) begin
            adv_state_d = IDLE;
            adv_done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            len_q         <= '0;
            idx_q         <= '0;
            presc_q       <= '0;
            dur_q         <= '0;
            gap_q         <= '0;
            enable_q      <= 1'b0;
            half_period_q <= '0;
            volume_q      <= '0;
            busy_q        <= 1'b0;
            note_idx_q    <= '0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (stop) begin
                state_q  <= IDLE;
                enable_q <= 1'b0;
                volume_q <= '0;
                busy_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start && len_ok) begin
                            len_q   <= length;
                            idx_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= LOAD;
                        end
                    end
                    LOAD: begin
                        half_period_q <= rd_hp;
                        note_idx_q    <= idx_q;
                        volume_q      <= master_volume;
                        enable_q      <= (rd_hp != '0);
                        dur_q         <= (rd_dur == '0) ? 12'd1 : rd_dur;
                        presc_q       <= '0;
                        state_q       <= PLAY;
                    end
                    PLAY: begin
                        presc_q <= tick ? '0 : presc_q + 1'b1;
                        if (tick) begin
                            dur_q <= dur_q - 1'b1;
                            if (dur_q == 12'd1) begin
                                enable_q <= 1'b0;
                                volume_q <= '0;
                                if (GAP_TICKS > 0) begin
                                    gap_q   <= GLEN;
                                    state_q <= GAP;
                                end else begin
                                    state_q <= adv_state_d;
                                    idx_q   <= adv_idx_d;
                                    done_q  <= adv_done_d;
                                    busy_q  <= !adv_done_d;
                                end
                            end
                        end
                    end
                    GAP: begin
                        presc_q <= tick ? '0 : presc_q + 1'b1;
                        if (tick) begin
                            gap_q <= gap_q - 1'b1;
                            if (gap_q == GW'(1)) begin
                                enable_q <= 1'b0;
                                volume_q <= '0;
                                state_q  <= adv_state_d;
                                idx_q    <= adv_idx_d;
                                done_q   <= adv_done_d;
                                busy_q   <= !adv_done_d;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign enable      = enable_q;
    assign half_period = half_period_q;
    assign volume      = volume_q;
    assign busy        = busy_q;
    assign note_idx    = note_idx_q;
    assign done        = done_q;

endmodule

// File: tb/tb_square_melody_sequencer.sv
// Bench for square_melody_sequencer: per-cycle comparison against a
// note-schedule model, plus hand-computed timing expectations.
module tb_square_melody_sequencer;

    localparam int TD = 4;
    localparam int GP = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [4:0]  length = '0;
    logic [15:0] master_volume = '0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [20:0] wr_half_period = '0;
    logic [11:0] wr_duration = '0;
    logic        enable;
    logic [20:0] half_period;
    logic [15:0] volume;
    logic        busy;
    logic [3:0]  note_idx;
    logic        done;

    int errors = 0;
    int checks = 0;

    square_melody_sequencer #(
        .TICK_DIV (TD),
        .GAP_TICKS(GP),
        .ADDR_W   (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .loop_en       (loop_en),
        .length        (length),
        .master_volume (master_volume),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_half_period(wr_half_period),
        .wr_duration   (wr_duration),
        .enable        (enable),
        .half_period   (half_period),
        .volume        (volume),
        .busy          (busy),
        .note_idx      (note_idx),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Model: a queue of future per-edge outputs, expanded note by note.
    localparam int K_PL  = 0;
    localparam int K_LD  = 1;
    localparam int K_ADV = 2;

    typedef struct {
        int          kind;
        logic        en;
        logic [20:0] hp;
        logic [15:0] vol;
        logic        busy;
        logic [3:0]  idx;
    } rec_t;

    rec_t        q[$];
    logic [20:0] t_hp [16];
    logic [11:0] t_dur[16];
    logic        m_en = 0;
    logic [20:0] m_hp = 0;
    logic [15:0] m_vol = 0;
    logic        m_busy = 0;
    logic [3:0]  m_idx = 0;
    logic        m_done = 0;
    int          m_cur = 0;
    int          m_len = 0;

    function automatic rec_t mk(int k, logic en, logic [20:0] hp,
                                logic [15:0] vol, logic b, logic [3:0] i);
        rec_t r;
        r.kind = k; r.en = en; r.hp = hp;
        r.vol = vol; r.busy = b; r.idx = i;
        return r;
    endfunction

    task automatic m_load();
        int d;
        d = (t_dur[m_cur] == 0) ? 1 : int'(t_dur[m_cur]);
        m_hp   = t_hp[m_cur];
        m_idx  = 4'(m_cur);
        m_vol  = master_volume;
        m_en   = (m_hp != 0);
        m_busy = 1;
        for (int i = 0; i < d * TD - 1; i++)
            q.push_back(mk(K_PL, m_en, m_hp, m_vol, 1, m_idx));
        for (int i = 0; i < GP * TD; i++)
            q.push_back(mk(K_PL, 0, m_hp, 16'd0, 1, m_idx));
        q.push_back(mk(K_ADV, 0, 0, 0, 0, 0));
    endtask

    task automatic m_adv();
        m_en  = 0;
        m_vol = 0;
        if (m_cur + 1 < m_len) begin
            m_cur++;
            q.push_back(mk(K_LD, 0, 0, 0, 0, 0));
        end else if (loop_en) begin
            m_cur = 0;
            q.push_back(mk(K_LD, 0, 0, 0, 0, 0));
        end else begin
            m_done = 1;
            m_busy = 0;
        end
    endtask

    task automatic m_step();
        rec_t r;
        bit   playing;
        playing = (q.size() != 0);
        m_done = 0;
        if (stop) begin
            q.delete();
            m_en = 0; m_vol = 0; m_busy = 0;
        end else if (playing) begin
            r = q.pop_front();
            if (r.kind == K_LD) m_load();
            else if (r.kind == K_ADV) m_adv();
            else begin
                m_en = r.en; m_hp = r.hp; m_vol = r.vol;
                m_busy = r.busy; m_idx = r.idx;
            end
        end else if (start && length >= 1 && length <= 16) begin
            m_len = int'(length);
            m_cur = 0;
            m_busy = 1; m_en = 0; m_vol = 0;
            q.push_back(mk(K_LD, 0, 0, 0, 0, 0));
        end
        if (wr_en) begin
            t_hp[wr_addr]  = wr_half_period;
            t_dur[wr_addr] = wr_duration;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_en = 0; m_hp = 0; m_vol = 0; m_busy = 0;
            m_idx = 0; m_done = 0; m_cur = 0; m_len = 0;
        end else begin
            m_step();
        end
    end

    always @(negedge clk) begin
        checks++;
        if ({enable, half_period, volume, busy, note_idx, done} !==
            {m_en, m_hp, m_vol, m_busy, m_idx, m_done}) begin
            errors++;
            $display("FAIL cycle t=%0t got en=%b hp=%0d vol=%0d busy=%b idx=%0d done=%b want en=%b hp=%0d vol=%0d busy=%b idx=%0d done=%b",
                     $time, enable, half_period, volume, busy, note_idx, done,
                     m_en, m_hp, m_vol, m_busy, m_idx, m_done);
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int hp, input int d);
        wr_en = 1; wr_addr = 4'(a);
        wr_half_period = 21'(hp); wr_duration = 12'(d);
        cyc();
        wr_en = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        cyc();
        start = 0;
    endtask

    task automatic run_while(input bit lvl, output int n);
        n = 0;
        while (enable === lvl && n < 200) begin
            n++;
            cyc();
        end
    endtask

    task automatic wait_idx_en(input int i, input string nm);
        int n = 0;
        while (!(note_idx == 4'(i) && enable) && n < 200) begin
            n++;
            cyc();
        end
        chk(nm, int'(note_idx == 4'(i) && enable), 1);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 400) begin
            n++;
            cyc();
        end
        chk(nm, int'(busy), 0);
    endtask

    initial begin
        int n;
        int hp_s;
        int seen;

        cyc();
        cyc();
        chk("rst_enable", int'(enable), 0);
        chk("rst_hp", int'(half_period), 0);
        chk("rst_volume", int'(volume), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_idx", int'(note_idx), 0);
        chk("rst_done", int'(done), 0);
        rst = 0;
        cyc();
        for (int a = 0; a < 16; a++)
            wr(a, int'($urandom_range(0, 5000)), int'($urandom_range(0, 3)));
        master_volume = 16'h1234;

        // Two notes, no loop.
        wr(0, 100, 2);
        wr(1, 200, 3);
        length = 2;
        pulse_start();
        run_while(0, n);
        chk("t1_load", n, 1);
        hp_s = int'(half_period);
        run_while(1, n);
        chk("t1_on0", n, 8);
        chk("t1_hp0", hp_s, 100);
        run_while(0, n);
        chk("t1_silence", n, 5);
        hp_s = int'(half_period);
        run_while(1, n);
        chk("t1_on1", n, 12);
        chk("t1_hp1", hp_s, 200);
        n = 0;
        while (!done && n < 50) begin n++; cyc(); end
        chk("t1_done", int'(done), 1);
        chk("t1_busy_at_done", int'(busy), 0);
        cyc();
        chk("t1_done_once", int'(done), 0);

        // Rest note.
        wr(0, 0, 2);
        length = 1;
        pulse_start();
        n = 0; seen = 0;
        while (busy && n < 100) begin
            n++;
            if (enable) seen = 1;
            cyc();
        end
        chk("rest_busy_cycles", n, 13);
        chk("rest_enable", seen, 0);
        chk("rest_done", int'(done), 1);

        // Zero duration acts as one tick.
        wr(0, 50, 0);
        pulse_start();
        run_while(0, n);
        run_while(1, n);
        chk("dur0_on", n, 4);
        wait_idle("dur0_idle");

        // Looping, then leaving the loop.
        wr(0, 100, 2);
        length = 2;
        loop_en = 1;
        pulse_start();
        wait_idx_en(1, "loop_note1");
        n = 0; seen = 0;
        while (!(note_idx == 0 && enable) && n < 100) begin
            if (done) seen = 1;
            n++;
            cyc();
        end
        chk("loop_restart", int'(note_idx == 0 && enable), 1);
        chk("loop_no_done", seen, 0);
        wait_idx_en(1, "loop_note1b");
        loop_en = 0;
        n = 0;
        while (!done && n < 100) begin n++; cyc(); end
        chk("loop_end_done", int'(done), 1);
        chk("loop_end_idx", int'(note_idx), 1);
        cyc();

        // Stop during note 1.
        pulse_start();
        wait_idx_en(1, "stop_note1");
        stop = 1;
        cyc();
        stop = 0;
        chk("stop_enable", int'(enable), 0);
        chk("stop_busy", int'(busy), 0);
        chk("stop_idx", int'(note_idx), 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) seen = 1;
            cyc();
        end
        chk("stop_no_done", seen, 0);

        // Start with stop in the same cycle; start with length 0.
        start = 1; stop = 1;
        cyc();
        start = 0; stop = 0;
        chk("startstop_busy", int'(busy), 0);
        cyc();
        chk("startstop_busy2", int'(busy), 0);
        length = 0;
        pulse_start();
        chk("len0_busy", int'(busy), 0);
        cyc();
        chk("len0_busy2", int'(busy), 0);
        length = 2;

        // A second start while busy is ignored.
        pulse_start();
        pulse_start();
        run_while(1, n);
        chk("restart_ignored_on", n, 8);
        wait_idle("restart_idle");

        // Reset in the middle of the gap.
        pulse_start();
        run_while(0, n);
        run_while(1, n);
        cyc();
        rst = 1;
        #1;
        chk("arst_out", int'({enable, half_period, volume, busy, note_idx, done}), 0);
        cyc();
        rst = 0;
        cyc();
        pulse_start();
        run_while(0, n);
        hp_s = int'(half_period);
        run_while(1, n);
        chk("arst_replay_hp", hp_s, 100);
        chk("arst_replay_on", n, 8);
        wait_idle("arst_idle");

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            start = ($urandom_range(0, 24) == 0);
            stop  = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) == 0) loop_en = ~loop_en;
            length = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                                 : 5'($urandom_range(1, 4));
            master_volume = 16'($urandom);
            wr_en = ($urandom_range(0, 7) == 0);
            wr_addr = 4'($urandom_range(0, 15));
            wr_half_period = ($urandom_range(0, 4) == 0) ? 21'd0 : 21'($urandom);
            wr_duration = 12'($urandom_range(0, 3));
            if ($urandom_range(0, 1499) == 0) begin
                wr_en = 0;
                rst = 1;
            end
            cyc();
            rst = 0;
        end
        start = 0; stop = 0; wr_en = 0;
        repeat (4) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
